xadc_drp_scheduler: RTL

Round-robin DRP read sequencer for the 7-series XADC in continuous-sequence mode. On each end-of-conversion pulse it reads every enabled auxiliary channel's status register over the DRP, one transaction at a time, and holds the latest 12-bit result per channel. It sits between the XADC primitive and the PWM/LED consumers, and replaces level-sensitive address muxing with a single clocked FSM owning den/daddr.

---
 rtl/xadc_drp_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/xadc_drp_scheduler.sv
// Round-robin DRP read sequencer for the XADC auxiliary channels in continuous-sequence mode.
// Define XADC_SCHED_AVG_EN to store a two-sample running average instead of the raw reading.
module xadc_drp_scheduler #(
    parameter logic [6:0]  ADDR0   = 7'h1E,
    parameter logic [6:0]  ADDR1   = 7'h17,
    parameter logic [6:0]  ADDR2   = 7'h1F,
    parameter logic [6:0]  ADDR3   = 7'h16,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  en_mask,
    input  logic        eoc,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic        den,
    output logic [6:0]  daddr,
    output logic [47:0] result,
    output logic [3:0]  valid,
    output logic        scan_done,
    output logic        timeout_err,
    output logic        overrun
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StStore} state_e;

    // Last WAIT cycle before the read is abandoned; WAIT lasts at most TIMEOUT cycles.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e           state_q;
    logic [1:0]       slot_q;
    logic [3:0]       scan_mask_q;
    logic [7:0]       cnt_q;
    logic [3:0][11:0] res_q;

    logic [1:0]  first_slot;
    logic [1:0]  next_slot;
    logic        next_found;
    logic [11:0] sample;
    logic [11:0] store_val;
    logic        unused_do_lsb;

    function automatic logic [6:0] slot_addr(input logic [1:0] s);
        logic [6:0] a;
        case (s)
            2'd0:    a = ADDR0;
            2'd1:    a = ADDR1;
            2'd2:    a = ADDR2;
            default: a = ADDR3;
        endcase
        return a;
    endfunction

    assign result        = res_q;
    assign sample        = do_in[15:4];
    assign unused_do_lsb = ^do_in[3:0];

    always_comb begin
        first_slot = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (en_mask[i]) first_slot = 2'(i);
        end
        next_found = 1'b0;
        next_slot  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (scan_mask_q[i] && (i > int'(slot_q))) begin
                next_found = 1'b1;
                next_slot  = 2'(i);
            end
        end
    end

`ifdef XADC_SCHED_AVG_EN
    logic [12:0] avg_sum;
    assign avg_sum   = {1'b0, res_q[slot_q]} + {1'b0, sample} + 13'd1;
    assign store_val = valid[slot_q] ? avg_sum[12:1] : sample;
`else
    assign store_val = sample;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            slot_q      <= 2'd0;
            scan_mask_q <= 4'd0;
            cnt_q       <= 8'd0;
            res_q       <= '0;
            den         <= 1'b0;
            daddr       <= ADDR0;
            valid       <= 4'd0;
            scan_done   <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            den       <= 1'b0;
            scan_done <= 1'b0;
            if (eoc && (state_q != StIdle)) overrun <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (eoc && (en_mask != 4'd0)) begin
                        scan_mask_q <= en_mask;
                        valid       <= valid & en_mask;
                        slot_q      <= first_slot;
                        daddr       <= slot_addr(first_slot);
                        den         <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= 8'd0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (drdy) begin
                        res_q[slot_q] <= store_val;
                        valid[slot_q] <= 1'b1;
                        state_q       <= StStore;
                    end else if (cnt_q == TimeoutLast) begin
                        // Slot abandoned: keep its previous result and valid bit.
                        timeout_err <= 1'b1;
                        state_q     <= StStore;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StStore: begin
                    if (next_found) begin
                        slot_q  <= next_slot;
                        daddr   <= slot_addr(next_slot);
                        den     <= 1'b1;
                        state_q <= StIssue;
                    end else begin
                        scan_done <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
